// File: rtl/ysyx_22050039_ifu_fetch.sv
// ysyx_22050039_ifu_fetch: instruction fetch stage. Holds the fetch PC, issues
// one outstanding imem read at a time, and buffers {pc, inst} pairs in a FIFO
// that feeds decode over a valid/ready handshake.
// Ports: clk, rst (async, active-low); imem_req_{valid,ready,addr} request
// channel; imem_resp_{valid,data} response pulse; redirect_{valid,pc} from
// execute; inst_{valid,ready}, inst, inst_pc to decode; fetch_err flag.
// Option: YSYX_22050039_IFU_ALIGN_CHECK_EN traps misaligned redirects in ERR.
module ysyx_22050039_ifu_fetch #(
   parameter int XLEN      = 64,
   parameter int INST_LEN  = 32,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [INST_LEN-1:0] imem_resp_data,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [INST_LEN-1:0] inst,
   output logic [XLEN-1:0]     inst_pc,
   output logic                fetch_err
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, DRAIN, ERR
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   buf_pc_q   [BUF_DEPTH];
   logic [INST_LEN-1:0] buf_inst_q [BUF_DEPTH];
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [PW:0]       count_q, count_d;

   logic              hs, resp_wait, resp_any, pop, push, flush;
   logic              misal;
   logic [XLEN-1:0]   tgt;

`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
   assign misal = |redirect_pc[1:0];
   assign tgt   = redirect_pc;
`else
   logic unused_lo;
   assign unused_lo = ^redirect_pc[1:0];
   assign misal = 1'b0;
   assign tgt   = {redirect_pc[XLEN-1:2], 2'b00};
`endif

   assign imem_req_valid = (state_q == REQ) && (count_q < DEPTH_C);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (count_q != '0);
   assign inst           = buf_inst_q[rd_ptr_q];
   assign inst_pc        = buf_pc_q[rd_ptr_q];
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
   assign fetch_err      = (state_q == ERR);
`else
   assign fetch_err      = 1'b0;
`endif

   assign hs        = imem_req_valid & imem_req_ready;
   assign resp_wait = (state_q == WAIT) & imem_resp_valid;
   assign resp_any  = imem_resp_valid;
   assign pop       = inst_valid & inst_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (redirect_valid) begin
         // redirect wins; any in-flight response is dropped
         flush = 1'b1;
         pc_d  = tgt;
         if (misal) begin
            state_d = ERR;
         end else begin
            case (state_q)
               REQ:     state_d = hs ? DRAIN : REQ;
               WAIT:    state_d = resp_wait ? REQ : DRAIN;
               DRAIN:   state_d = resp_any ? REQ : DRAIN;
               default: state_d = REQ;
            endcase
         end
      end else begin
         case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (hs) state_d = WAIT;
            WAIT: begin
               if (resp_wait) begin
                  push    = 1'b1;
                  pc_d    = pc_q + XLEN'(4);
                  state_d = REQ;
               end
            end
            DRAIN: if (resp_any) state_d = REQ;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_pc_q[i]   <= '0;
            buf_inst_q[i] <= '0;
         end
      end else if (flush) begin
         // a coincident pop was taken by decode; the rest is discarded
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            buf_pc_q[wr_ptr_q]   <= pc_q;
            buf_inst_q[wr_ptr_q] <= imem_resp_data;
            wr_ptr_q             <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050039_ifu_fetch.sv
// tb_ysyx_22050039_ifu_fetch: directed vector table plus hand-written
// sequences for mid-transaction reset and redirect-during-handshake.
module tb_ysyx_22050039_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        fetch_err;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   ysyx_22050039_ifu_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .fetch_err       (fetch_err)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        rdr;
      logic [63:0] rpc;
      logic        irdy;
      logic        erq;
      logic [63:0] eaddr;
      logic        eiv;
      logic [31:0] einst;
      logic [63:0] eipc;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      logic rdy, logic rv, logic [31:0] rd,
      logic rdr, logic [63:0] rpc, logic irdy,
      logic erq, logic [63:0] eaddr, logic eiv,
      logic [31:0] einst, logic [63:0] eipc, logic eerr);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rd = rd;
      v.rdr = rdr; v.rpc = rpc; v.irdy = irdy;
      v.erq = erq; v.eaddr = eaddr; v.eiv = eiv;
      v.einst = einst; v.eipc = eipc; v.eerr = eerr;
      vecs.push_back(v);
   endfunction

   task automatic check(string nm, logic erq, logic [63:0] eaddr,
                        logic eiv, logic [31:0] einst,
                        logic [63:0] eipc, logic eerr);
      logic [31:0] gi;
      logic [63:0] gp;
      gi = eiv ? inst : einst;
      gp = eiv ? inst_pc : eipc;
      total++;
      if ({imem_req_valid, imem_req_addr, inst_valid, gi, gp, fetch_err} ===
          {erq, eaddr, eiv, einst, eipc, eerr}) begin
         passed++;
      end else begin
         $display("FAIL %s: got rq=%0b addr=%h iv=%0b inst=%h pc=%h err=%0b want rq=%0b addr=%h iv=%0b inst=%h pc=%h err=%0b",
                  nm, imem_req_valid, imem_req_addr, inst_valid, inst,
                  inst_pc, fetch_err, erq, eaddr, eiv, einst, eipc, eerr);
      end
   endtask

   task automatic drive(logic rdy, logic rv, logic [31:0] rd,
                        logic rdr, logic [63:0] rpc, logic irdy);
      imem_req_ready  = rdy;
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      redirect_valid  = rdr;
      redirect_pc     = rpc;
      inst_ready      = irdy;
   endtask

   localparam logic [63:0] B = 64'h8000_0000;

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      // fetch, fill, back-pressure
      add(1,0,0,0,0,0, 0,B,0,0,0,0);
      add(1,0,0,0,0,0, 1,B,0,0,0,0);
      add(1,1,32'h00000413,0,0,0, 0,B,0,0,0,0);
      add(1,0,0,0,0,0, 1,B+4,1,32'h00000413,B,0);
      add(1,1,32'h00100093,0,0,0, 0,B+4,1,32'h00000413,B,0);
      for (int i = 0; i < 3; i++)
         add(1,0,0,0,0,0, 0,B+8,1,32'h00000413,B,0);
      add(1,0,0,0,0,1, 0,B+8,1,32'h00000413,B,0);
      add(1,0,0,0,0,1, 1,B+8,1,32'h00100093,B+4,0);
      add(1,1,32'h00200113,0,0,0, 0,B+8,0,0,0,0);
      add(0,0,0,0,0,1, 1,B+12,1,32'h00200113,B+8,0);
      // request held off by memory
      for (int i = 0; i < 5; i++)
         add(0,0,0,0,0,0, 1,B+12,0,0,0,0);
      add(1,0,0,0,0,0, 1,B+12,0,0,0,0);
      // redirect in WAIT, late response discarded
      add(0,0,0,1,B+64'h100,0, 0,B+12,0,0,0,0);
      add(0,0,0,0,0,0, 0,B+64'h100,0,0,0,0);
      add(0,0,0,0,0,0, 0,B+64'h100,0,0,0,0);
      add(0,1,32'hdeadbeef,0,0,0, 0,B+64'h100,0,0,0,0);
      add(1,0,0,0,0,0, 1,B+64'h100,0,0,0,0);
      add(0,1,32'h11111111,0,0,0, 0,B+64'h100,0,0,0,0);
      add(1,0,0,0,0,0, 1,B+64'h104,1,32'h11111111,B+64'h100,0);
      // redirect with response and pop in the same cycle
      add(0,1,32'h22222222,1,B+64'h200,1,
          0,B+64'h104,1,32'h11111111,B+64'h100,0);
      add(1,0,0,0,0,0, 1,B+64'h200,0,0,0,0);
      add(0,1,32'h33333333,0,0,0, 0,B+64'h200,0,0,0,0);
      // misaligned redirect
      add(0,0,0,1,B+64'h102,0,
          1,B+64'h204,1,32'h33333333,B+64'h200,0);
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
      add(1,0,0,0,0,0, 0,B+64'h102,0,0,0,1);
      add(1,0,0,1,B+64'h104,0, 0,B+64'h102,0,0,0,1);
      add(1,0,0,0,0,0, 1,B+64'h104,0,0,0,0);
`else
      add(1,0,0,0,0,0, 1,B+64'h100,0,0,0,0);
      add(0,0,0,1,B+64'h104,0, 0,B+64'h100,0,0,0,0);
      add(0,0,0,0,0,0, 0,B+64'h104,0,0,0,0);
`endif

      @(negedge clk);
      @(negedge clk);
      check("reset", 0, B, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rdy, vecs[i].rv, vecs[i].rd,
               vecs[i].rdr, vecs[i].rpc, vecs[i].irdy);
         #1;
         check($sformatf("row%0d", i), vecs[i].erq, vecs[i].eaddr,
               vecs[i].eiv, vecs[i].einst, vecs[i].eipc, vecs[i].eerr);
         @(negedge clk);
      end

      // asynchronous reset mid-transaction, late response ignored
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      check("async_rst", 0, B, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1, 32'hbad0bad0, 0, 0, 0);
      #1;
      check("late_idle", 0, B, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 1, 32'hbad1bad1, 0, 0, 0);
      #1;
      check("late_req", 1, B, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 0, 0, 1, B+64'h300, 0);
      #1;
      check("req_hold", 1, B, 0, 0, 0, 0);
      // redirect during handshake: drain old response
      @(negedge clk);
      drive(1, 1, 32'hcafecafe, 0, 0, 0);
      #1;
      check("drain", 0, B+64'h300, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
      #1;
      check("after_drain", 1, B+64'h300, 0, 0, 0, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
